// File: rtl/lab7_seq_det.sv
// lab7_seq_det -- serial pattern detector with a loadable pattern.
//
// Serial bits are shifted into a PAT_W-bit history register. A fill counter
// tracks how many valid bits the history holds. found pulses for one cycle
// after the edge that accepted a completing bit. The overlap input selects
// whether the bits of a match may also start the next match.
//
// Optional feature: define SEQDET_COUNT_EN to add the match_cnt output. It is
// a saturating count of matches, cleared on reset and on load. Without the
// macro, the port and its logic are absent.
module lab7_seq_det #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             d_valid,
  input  logic             d_in,
  output logic             found
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  // The fill counter must be able to hold PAT_W itself, not only PAT_W-1.
  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  history;
  logic [FILL_W-1:0] fill;

  logic              accept;
  logic [PAT_W-1:0]  history_next;
  logic [FILL_W-1:0] fill_next;
  logic              match;

  // Compute the post-shift history and fill for this edge, and decide whether they complete a match.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    accept       = 1'b0;
    history_next = history;
    fill_next    = fill;
    match        = 1'b0;

    accept       = d_valid & ~load;
    history_next = {history[PAT_W-2:0], d_in};
    fill_next    = (fill == FULL) ? fill : fill + 1'b1;
    match        = accept && (fill_next == FULL) && (history_next == pattern);
  end

  // Update the pattern, history, fill and found registers. Load wins over data, and only the completing edge samples overlap.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= RST_PAT;
      history <= '0;
      fill    <= '0;
      found   <= 1'b0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments, so every register updates from values sampled before this edge.
      pattern <= pat_in;
      fill    <= '0;
      found   <= 1'b0;
    end else if (accept) begin
      history <= history_next;
      fill    <= (match && !overlap) ? '0 : fill_next;
      found   <= match;
    end else begin
      found   <= 1'b0;
    end
  end

`ifdef SEQDET_COUNT_EN
  // Count matches since reset or load. The count holds at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (load) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lab7_seq_det.sv
// tb_lab7_seq_det -- scoreboard testbench for lab7_seq_det.
// Each driven cycle pushes the expected found value to a queue. The value is
// popped and compared on the falling edge after the active edge. match_cnt
// checks exist only when SEQDET_COUNT_EN is defined.
module tb_lab7_seq_det;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] pat_in;
  logic       overlap;
  logic       d_valid;
  logic       d_in;
  logic       found;
  logic       found_sat;
`ifdef SEQDET_COUNT_EN
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_sat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    logic  exp_found;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  lab7_seq_det #(.PAT_W(4), .RST_PAT(4'b1101), .CNT_W(8)) dut (
    .clock   (clk),
    .rst_n   (rst_n),
    .load    (load),
    .pat_in  (pat_in),
    .overlap (overlap),
    .d_valid (d_valid),
    .d_in    (d_in),
    .found   (found)
`ifdef SEQDET_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  // A second instance with a 2-bit counter, used to exercise saturation.
  lab7_seq_det #(.PAT_W(4), .RST_PAT(4'b1101), .CNT_W(2)) dut_sat (
    .clock   (clk),
    .rst_n   (rst_n),
    .load    (load),
    .pat_in  (pat_in),
    .overlap (overlap),
    .d_valid (d_valid),
    .d_in    (d_in),
    .found   (found_sat)
`ifdef SEQDET_COUNT_EN
    ,
    .match_cnt (match_cnt_sat)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge and push the expected found value. After the rising edge, pop that value and compare it at the next falling edge.
  task automatic cycle(input string tag, input logic v, input logic b, input logic ld,
                       input logic [3:0] pat, input logic exp_found);
    exp_t e;
    load    = ld;
    pat_in  = pat;
    d_valid = v;
    d_in    = b;
    sb_q.push_back('{tag: tag, exp_found: exp_found});
    @(posedge clk);
    @(negedge clk);
    load    = 1'b0;
    d_valid = 1'b0;
    d_in    = 1'b0;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, found, e.exp_found);
      check({e.tag, "_sat"}, found_sat, e.exp_found);
    end
  endtask

  // Accept a bit string, oldest bit first, with one expected found value per bit.
  task automatic stream(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      cycle($sformatf("%s_b%0d", tag, n - i), 1'b1, bits[i], 1'b0, 4'b0000, exp[i]);
    end
  endtask

  // Assert reset between clock edges and check that it clears outputs asynchronously. Release it on the next falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_found"}, found, 0);
`ifdef SEQDET_COUNT_EN
    check({tag, "_cnt"}, match_cnt, 0);
    check({tag, "_cnt_sat"}, match_cnt_sat, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_cnt(input string tag, input int exp, input int exp_sat);
`ifdef SEQDET_COUNT_EN
    check(tag, match_cnt, exp);
    check({tag, "_sat"}, match_cnt_sat, exp_sat);
`else
    if (exp < 0 || exp_sat < 0) check(tag, 0, 1);
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    pat_in  = 4'b0000;
    overlap = 1'b1;
    d_valid = 1'b0;
    d_in    = 1'b0;
    @(negedge clk);
    check("reset_found", found, 0);
    check_cnt("reset_cnt", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern 1101 with overlap: stream 1101101 matches on bits 4 and 7.
    overlap = 1'b1;
    stream("ovl1", 7, 16'b1101101, 16'b0001001);
    check_cnt("ovl1_cnt", 2, 2);

    // The same stream without overlap matches on bit 4 only.
    do_reset("rst_a");
    overlap = 1'b0;
    stream("ovl0", 7, 16'b1101101, 16'b0001000);
    check_cnt("ovl0_cnt", 1, 1);

    // Load 1111. With overlap, 11111 matches on bits 4 and 5.
    overlap = 1'b1;
    cycle("load1111_a", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    check_cnt("load_clr_cnt", 0, 0);
    stream("p1111_ovl1", 5, 16'b11111, 16'b00011);
    check_cnt("p1111_ovl1_cnt", 2, 2);
    overlap = 1'b0;
    cycle("load1111_b", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    stream("p1111_ovl0", 5, 16'b11111, 16'b00010);
    check_cnt("p1111_ovl0_cnt", 1, 1);

    // Pattern 1101 fed one bit at a time with three idle cycles between bits.
    do_reset("rst_b");
    overlap = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] bits;
      bits = 4'b1101;
      cycle($sformatf("gap_b%0d", 4 - i), 1'b1, bits[i], 1'b0, 4'b0000, (i == 0));
      for (int g = 0; g < 3; g++) begin
        cycle($sformatf("gap_idle%0d_%0d", 4 - i, g), 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      end
    end
    check_cnt("gap_cnt", 1, 1);

    // Load collides with a valid bit: the bit is dropped and the fill restarts.
    do_reset("rst_c");
    stream("pre_load", 3, 16'b110, 16'b000);
    cycle("load_vs_valid", 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
    stream("post_load", 4, 16'b1101, 16'b0001);
    check_cnt("post_load_cnt", 1, 1);

    // Reset after 110. Without the reset, the next 1 would complete 1101.
    overlap = 1'b0;
    stream("pre_rst", 3, 16'b110, 16'b000);
    do_reset("rst_mid");
    cycle("post_rst_b1", 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);

    // Saturation: pattern 1111 with overlap, eight ones give five matches.
    do_reset("rst_d");
    overlap = 1'b1;
    cycle("load_sat", 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    stream("sat", 8, 16'b11111111, 16'b00011111);
    check_cnt("sat_cnt", 5, 3);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Bound the run so a stalled bench still ends with a report.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
